// File: rtl/io_map_pkg.sv
// I/O map shared by the CPU-side peripheral decoders.
// Each peripheral register is selected by one address bit inside the
// I/O window, which is enabled by IO_BASE_bit.
package io_map_pkg;

  // I/O window enable bit (0x0000_0100)
  localparam int IO_BASE_bit  = 8;

  // Register select bits inside the I/O window
  localparam int IO_LEDS_bit  = 2;   // 0x0000_0104
  localparam int IO_HEX_bit   = 3;   // 0x0000_0108
  localparam int IO_SW_bit    = 4;   // 0x0000_0110 switch state
  localparam int IO_SWEV_bit  = 5;   // 0x0000_0120 switch events
  localparam int IO_SWMSK_bit = 6;   // 0x0000_0140 switch irq mask

  // Field offsets shared by the event and mask registers
  localparam int RISE_LSB = 0;
  localparam int FALL_LSB = 16;

  // Which switch register drives the read mux
  typedef enum logic [1:0] {
    RSEL_NONE  = 2'd0,
    RSEL_STATE = 2'd1,
    RSEL_EVENT = 2'd2,
    RSEL_MASK  = 2'd3
  } rd_sel_e;

  // Lowest select bit wins when several are set on a read
  function automatic rd_sel_e pick_rd_sel(input logic sel_sw,
                                          input logic sel_ev,
                                          input logic sel_msk);
    rd_sel_e s;
    if (sel_sw)       s = RSEL_STATE;
    else if (sel_ev)  s = RSEL_EVENT;
    else if (sel_msk) s = RSEL_MASK;
    else              s = RSEL_NONE;
    return s;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Switch synchroniser and tick-sampled debouncer.
// A pin change is accepted into sw_state only after two consecutive tick
// samples agree. rise_set/fall_set pulse on the same clk that sw_state
// changes so the event flags can be set in step with it.
module sw_debounce #(
  parameter int N_SW            = 10,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_SW-1:0] sw_async,
  output logic [N_SW-1:0] sw_state,
  output logic [N_SW-1:0] rise_set,
  output logic [N_SW-1:0] fall_set
);

  localparam int             CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_SW-1:0] sync1;
  logic [N_SW-1:0] sync2;
  logic [N_SW-1:0] sample;
  logic [N_SW-1:0] accept;
  logic [CW-1:0]   cnt;
  logic            tick;

  // Two-flop synchroniser per switch pin
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_async;
      sync2 <= sync1;
    end
  end

  // Free-running sample-tick counter, wraps at DEBOUNCE_CYCLES-1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CNT_LAST);

  // A bit is accepted when this tick's sample matches the previous one
  // and differs from the debounced state
  assign accept   = tick ? (~(sync2 ^ sample) & (sync2 ^ sw_state)) : '0;
  assign rise_set = accept & sync2;
  assign fall_set = accept & ~sync2;

  // Sample register and debounced state, both advanced only on tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample   <= '0;
      sw_state <= '0;
    end else if (tick) begin
      sample   <= sync2;
      sw_state <= (sw_state & ~accept) | (sync2 & accept);
    end
  end

endmodule

// File: rtl/io_switch_port.sv
// Memory-mapped switch input responder on the CPU I/O bus.
// Registers: state (read-only), sticky rise/fall events (write-1-to-clear)
// and an irq mask. irq is the registered OR of masked events.
//
// Bus handshake: there is no valid/ready pair. A load or store is presented
// for one clk as addr (plus memwrite/writedata for a store); a store takes
// effect on that clk edge, and the read response appears on io_rdata one
// clk later, qualified by io_hit. Every access is accepted immediately.
module io_switch_port #(
  parameter int N_SW            = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int IO_SW_bit       = io_map_pkg::IO_SW_bit,
  parameter int IO_SWEV_bit     = io_map_pkg::IO_SWEV_bit,
  parameter int IO_SWMSK_bit    = io_map_pkg::IO_SWMSK_bit
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_SW-1:0] sw_async,
  input  logic [31:0]     addr,
  input  logic [31:0]     writedata,
  input  logic            memwrite,
  output logic [31:0]     io_rdata,
  output logic            io_hit,
  output logic [N_SW-1:0] sw_state,
  output logic            irq
);

  import io_map_pkg::*;

  logic            is_io;
  logic            sel_sw;
  logic            sel_ev;
  logic            sel_msk;
  rd_sel_e         rd_sel;

  logic [N_SW-1:0] rise_set;
  logic [N_SW-1:0] fall_set;
  logic [N_SW-1:0] rise;
  logic [N_SW-1:0] fall;
  logic [N_SW-1:0] mask_lo;
  logic [N_SW-1:0] mask_hi;
  logic [N_SW-1:0] w1c_lo;
  logic [N_SW-1:0] w1c_hi;

  logic [31:0]     state_word;
  logic [31:0]     event_word;
  logic [31:0]     mask_word;
  logic [31:0]     rd_next;

  // Only some address and data bits are decoded
  wire unused_bits = ^{addr, writedata};

  sw_debounce #(
    .N_SW            (N_SW),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .reset_n  (reset_n),
    .sw_async (sw_async),
    .sw_state (sw_state),
    .rise_set (rise_set),
    .fall_set (fall_set)
  );

  // Address decode; writes act on every selected register
  assign is_io   = addr[IO_BASE_bit];
  assign sel_sw  = is_io & addr[IO_SW_bit];
  assign sel_ev  = is_io & addr[IO_SWEV_bit];
  assign sel_msk = is_io & addr[IO_SWMSK_bit];
  assign rd_sel  = pick_rd_sel(sel_sw, sel_ev, sel_msk);

  assign w1c_lo = (memwrite & sel_ev) ? writedata[RISE_LSB +: N_SW] : '0;
  assign w1c_hi = (memwrite & sel_ev) ? writedata[FALL_LSB +: N_SW] : '0;

  // Sticky event flags: a new edge wins over a same-clk clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise <= '0;
      fall <= '0;
    end else begin
      rise <= (rise & ~w1c_lo) | rise_set;
      fall <= (fall & ~w1c_hi) | fall_set;
    end
  end

  // Interrupt mask, loaded whole on a store to the mask register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_lo <= '0;
      mask_hi <= '0;
    end else if (memwrite & sel_msk) begin
      mask_lo <= writedata[RISE_LSB +: N_SW];
      mask_hi <= writedata[FALL_LSB +: N_SW];
    end
  end

  // Registered interrupt, follows flags and mask by one clk
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |((rise & mask_lo) | (fall & mask_hi));
    end
  end

  // Register images and read mux
  always_comb begin
    state_word                     = '0;
    state_word[N_SW-1:0]           = sw_state;
    event_word                     = '0;
    event_word[RISE_LSB +: N_SW]   = rise;
    event_word[FALL_LSB +: N_SW]   = fall;
    mask_word                      = '0;
    mask_word[RISE_LSB +: N_SW]    = mask_lo;
    mask_word[FALL_LSB +: N_SW]    = mask_hi;
    rd_next                        = '0;
    case (rd_sel)
      RSEL_STATE: rd_next = state_word;
      RSEL_EVENT: rd_next = event_word;
      RSEL_MASK:  rd_next = mask_word;
      default:    rd_next = '0;
    endcase
  end

  // One-clk read response, like a synchronous RAM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      io_rdata <= '0;
      io_hit   <= 1'b0;
    end else begin
      io_rdata <= rd_next;
      io_hit   <= sel_sw | sel_ev | sel_msk;
    end
  end

endmodule

// File: tb/tb_io_switch_port.sv
// Bench for io_switch_port with a 4-clk debounce tick.
// Bus accesses push the expected response into a queue; a monitor pops and
// compares one clk after each access. Switch state, flags and mask are
// modelled from the register-level rules, only at settled points.
module tb_io_switch_port;

  localparam int N_SW   = 10;
  localparam int DB     = 4;
  localparam int SETTLE = 2 + 2 * DB + 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N_SW-1:0] sw_async = '0;
  logic [31:0]     addr = '0;
  logic [31:0]     writedata = '0;
  logic            memwrite = 1'b0;
  logic [31:0]     io_rdata;
  logic            io_hit;
  logic [N_SW-1:0] sw_state;
  logic            irq;

  io_switch_port #(
    .N_SW            (N_SW),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sw_async  (sw_async),
    .addr      (addr),
    .writedata (writedata),
    .memwrite  (memwrite),
    .io_rdata  (io_rdata),
    .io_hit    (io_hit),
    .sw_state  (sw_state),
    .irq       (irq)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // posedges since reset release, used to place glitch edges
  int cyc;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic        hit_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [N_SW-1:0] m_sw, m_rise, m_fall, m_mlo, m_mhi;

  function automatic void model_reset();
    m_sw = '0; m_rise = '0; m_fall = '0; m_mlo = '0; m_mhi = '0;
  endfunction

  function automatic void apply_switch(input logic [N_SW-1:0] v);
    m_rise = m_rise | (v & ~m_sw);
    m_fall = m_fall | (m_sw & ~v);
    m_sw   = v;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, output logic hit);
    logic [31:0] w;
    w   = '0;
    hit = a[8] & (a[4] | a[5] | a[6]);
    if (a[8] && a[4]) begin
      w[N_SW-1:0] = m_sw;
    end else if (a[8] && a[5]) begin
      w[N_SW-1:0] = m_rise;
      w[16 +: N_SW] = m_fall;
    end else if (a[8] && a[6]) begin
      w[N_SW-1:0] = m_mlo;
      w[16 +: N_SW] = m_mhi;
    end
    return w;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] wd);
    if (a[8] && a[5]) begin
      m_rise = m_rise & ~wd[N_SW-1:0];
      m_fall = m_fall & ~wd[16 +: N_SW];
    end
    if (a[8] && a[6]) begin
      m_mlo = wd[N_SW-1:0];
      m_mhi = wd[16 +: N_SW];
    end
  endfunction

  function automatic logic model_irq();
    return |((m_rise & m_mlo) | (m_fall & m_mhi));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic bus_cycle(input logic [31:0] a, input logic [31:0] wd, input logic we);
    logic        h;
    logic [31:0] d;
    @(negedge clk);
    addr = a; writedata = wd; memwrite = we;
    d = model_read(a, h);
    hit_q.push_back(h);
    if (h) exp_q.push_back(d);
    @(posedge clk);
    if (we) model_write(a, wd);
    #1;
    addr = '0; writedata = '0; memwrite = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic [N_SW-1:0] v);
    @(negedge clk);
    sw_async = v;
    idle(SETTLE);
    apply_switch(v);
    chk("settle_sw_state", 32'(sw_state), 32'(v));
  endtask

  // ---------------- monitor ----------------
  logic        mon_h;
  logic [31:0] mon_d;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (hit_q.size() > 0) begin
        mon_h = hit_q.pop_front();
        chk("io_hit", 32'(io_hit), 32'(mon_h));
        if (mon_h) begin
          mon_d = exp_q.pop_front();
          chk("io_rdata", io_rdata, mon_d);
        end
      end else if (io_hit !== 1'b0) begin
        chk("idle_io_hit", 32'(io_hit), 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] addr_tab [13];
  logic        found;
  int          n;

  initial begin
    addr_tab = '{32'h110, 32'h120, 32'h140, 32'h130, 32'h150, 32'h160, 32'h170,
                 32'h100, 32'h104, 32'h108, 32'h010, 32'h020, 32'h040};
    model_reset();

    // Reset with all switches high: outputs stay 0 while held
    sw_async = 10'h3FF;
    idle(3);
    chk("rst_io_rdata", io_rdata, 32'd0);
    chk("rst_io_hit", 32'(io_hit), 32'd0);
    chk("rst_sw_state", 32'(sw_state), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    while (sw_state !== 10'h3FF && n < 2 + 2 * DB) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("release_sw_state", 32'(sw_state), 32'h3FF);
    apply_switch(10'h3FF);
    bus_cycle(32'h120, 32'd0, 1'b0);
    chk("release_events", io_rdata, 32'h0000_03FF);

    // Glitching switch 0 must never be accepted
    bus_cycle(32'h120, 32'hFFFF_FFFF, 1'b1);
    settle(10'h000);
    bus_cycle(32'h120, 32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      // tick sampling lands on even cycles since reset; keep the pin 0 there
      sw_async[0] = (cyc % 2 == 0);
      @(posedge clk);
      #1;
      chk("glitch_sw0", 32'(sw_state[0]), 32'd0);
    end
    @(negedge clk);
    sw_async[0] = 1'b0;
    idle(SETTLE);
    bus_cycle(32'h120, 32'd0, 1'b0);
    chk("glitch_no_event", io_rdata, 32'd0);

    // State register read, store to it is ignored
    settle(10'h008);
    bus_cycle(32'h110, 32'd0, 1'b0);
    chk("state_read", io_rdata, 32'h0000_0008);
    chk("state_read_hit", 32'(io_hit), 32'd1);
    bus_cycle(32'h110, 32'hFFFF_FFFF, 1'b1);
    bus_cycle(32'h110, 32'd0, 1'b0);
    bus_cycle(32'h120, 32'd0, 1'b0);
    bus_cycle(32'h140, 32'd0, 1'b0);

    // rise[3] and fall[5] set, W1C rise[3]
    bus_cycle(32'h120, 32'hFFFF_FFFF, 1'b1);
    settle(10'h020);
    bus_cycle(32'h120, 32'hFFFF_FFFF, 1'b1);
    settle(10'h008);
    bus_cycle(32'h120, 32'h0000_0008, 1'b1);
    bus_cycle(32'h120, 32'd0, 1'b0);
    chk("w1c_rise3", io_rdata, 32'h0020_0000);

    // irq from a masked fall on switch 5
    bus_cycle(32'h120, 32'hFFFF_FFFF, 1'b1);
    settle(10'h028);
    bus_cycle(32'h120, 32'hFFFF_FFFF, 1'b1);
    bus_cycle(32'h140, 32'h0020_0000, 1'b1);
    idle(2);
    chk("irq_before_fall", 32'(irq), 32'd0);
    @(negedge clk);
    sw_async = 10'h008;
    n = 0;
    while (sw_state[5] !== 1'b0 && n < SETTLE) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("fall5_seen", 32'(sw_state[5]), 32'd0);
    apply_switch(10'h008);
    n = 0;
    while (irq !== 1'b1 && n < 2) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("irq_after_fall", 32'(irq), 32'd1);
    bus_cycle(32'h120, 32'h0020_0000, 1'b1);
    idle(1);
    chk("irq_after_w1c", 32'(irq), 32'(model_irq()));

    // Set and W1C of rise[0] on the same clk: set wins
    @(negedge clk);
    sw_async = 10'h009;
    found = 1'b0;
    for (int i = 0; i < SETTLE + 4 && !found; i++) begin
      bus_cycle(32'h120, 32'h0000_0001, 1'b1);
      if (sw_state[0] === 1'b1) begin
        found = 1'b1;
        apply_switch(10'h009);
      end
    end
    chk("setwins_seen", 32'(found), 32'd1);
    bus_cycle(32'h120, 32'd0, 1'b0);
    chk("setwins_flag", 32'(io_rdata[0]), 32'd1);

    // Asynchronous reset in mid-cycle clears everything at once
    bus_cycle(32'h140, 32'hFFFF_FFFF, 1'b1);
    idle(2);
    chk("irq_all_mask", 32'(irq), 32'(model_irq()));
    bus_cycle(32'h110, 32'd0, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_io_rdata", io_rdata, 32'd0);
    chk("async_rst_io_hit", 32'(io_hit), 32'd0);
    chk("async_rst_sw_state", 32'(sw_state), 32'd0);
    chk("async_rst_irq", 32'(irq), 32'd0);
    model_reset();
    idle(2);
    @(negedge clk);
    reset_n = 1'b1;
    settle(10'h009);
    bus_cycle(32'h120, 32'd0, 1'b0);
    bus_cycle(32'h140, 32'd0, 1'b0);
    idle(1);
    chk("irq_after_reset", 32'(irq), 32'(model_irq()));

    // Random mix of switch changes, reads, writes and irq checks
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: settle(N_SW'($urandom_range(0, 1023)));
        1: bus_cycle(addr_tab[$urandom_range(0, 12)], 32'd0, 1'b0);
        2: bus_cycle(addr_tab[$urandom_range(0, 12)], $urandom, 1'b1);
        default: begin
          idle(2);
          chk("irq_rand", 32'(irq), 32'(model_irq()));
        end
      endcase
    end

    idle(3);
    chk("queue_drained", 32'(hit_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
